sram_arbiter: RTL
=================

# sram_arbiter

Shares the single off-chip 16-bit SRAM between two requesters: port 0 (recorder, writes samples) and port 1 (DSP/player, reads samples). Each port issues one-word requests through a req/gnt handshake; the arbiter grants one port at a time, sequences the SRAM control strobes, and returns read data with a valid pulse. It sits between the recorder/DSP blocks and the `o_SRAM_*`/`io_SRAM_DQ` board pins inside the audio top level, clocked by the 12 MHz audio clock.

## Interface
- `ADDR_W`, 20, SRAM word-address width
- `DATA_W`, 16, SRAM data width
- `i_clk` input 1 — system clock (12 MHz)
- `i_rst` input 1 — synchronous reset, active-high
- `i_req[1:0]` input 2 — per-port access request, level
- `i_we[1:0]` input 2 — per-port 1 = write, 0 = read
- `i_addr0`, `i_addr1` input ADDR_W — per-port word address
- `i_wdata0`, `i_wdata1` input DATA_W — per-port write data
- `o_gnt[1:0]` output 2 — one-cycle grant pulse, one-hot or zero
- `o_rdata` output DATA_W — read data, shared by both ports
- `o_rvalid[1:0]` output 2 — one-cycle read-data-valid pulse, per port
- `o_busy` output 1 — high whenever state ≠ IDLE
- `o_SRAM_ADDR` output ADDR_W; `io_SRAM_DQ` inout DATA_W; `o_SRAM_WE_N`, `o_SRAM_CE_N`, `o_SRAM_OE_N`, `o_SRAM_LB_N`, `o_SRAM_UB_N` output 1

## Operation
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE: if any `i_req` is high, pick the winner, latch its addr/we/wdata into internal registers, pulse `o_gnt[winner]`, and go to ACCESS. With no request, stay in IDLE.
- ACCESS, 1 cycle: drive the latched address. Write: `WE_N`=0, DQ driven with latched data, `OE_N`=1. Read: `OE_N`=0, DQ hi-Z, `WE_N`=1, DQ sampled into `o_rdata` at the end of the cycle. Next state is RECOVER for a write and IDLE for a read.
- RECOVER, 1 cycle, writes only: `WE_N`=1 and DQ still driven, which holds the data past the WE rising edge. Next state is IDLE.
- `CE_N`, `LB_N`, `UB_N` are 0 in every state outside reset.
- DQ is driven only in ACCESS(write) and RECOVER. It is hi-Z in all other states.
- Requester rules:
  - Hold `i_req`, `i_we`, addr and wdata stable until `o_gnt` is seen.
  - Inputs may change the cycle after `o_gnt`.
  - Keeping `i_req` high issues the next request.
  - A port must not drop `i_req` before grant. If it does, the request is simply not served.
- Arbitration when both ports request in the same IDLE cycle: see Configuration.
- `o_rdata` holds its last value between reads.

## Timing
- Grant in cycle N means:
  - Read: ACCESS in N+1, `o_rvalid[port]` high in N+2, ready for the next grant in N+2. A read takes 2 cycles.
  - Write: ACCESS in N+1, RECOVER in N+2, next grant in N+3. A write takes 3 cycles.
- `o_gnt` is registered and coincides with the IDLE cycle in which the request is latched.
- `o_rvalid` and `o_gnt` may be high in the same cycle (read completes while the next grant is issued).
- Reset values:
  - `o_gnt`=0, `o_rvalid`=0, `o_busy`=0, `o_rdata`=0
  - `o_SRAM_ADDR`=0, `WE_N`=1, `OE_N`=1, `CE_N`=1, `LB_N`=1, `UB_N`=1, DQ hi-Z
  - state IDLE; round-robin pointer = port 0
- Reset mid-operation: on the next edge the FSM returns to IDLE and the strobes go inactive. The in-flight access is abandoned: no `o_rvalid`, and write completion is undefined.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - 1-bit pointer names the favoured port.
  - After each grant the pointer moves to the other port.
  - With both ports requesting continuously, grants alternate 0, 1, 0, 1…
- Not defined: fixed priority, port 0 (recorder) always wins. No pointer register exists.

## Structure
- Package `sram_arb_pkg`:
  - FSM state enum
  - `ADDR_W`/`DATA_W` default constants
  - `port_id_t` typedef (1 bit)
- Sub-module `sram_arb_pick`: combinational winner selection from `i_req` and the pointer. It holds the `SRAM_ARB_RR_EN` variants.
- Tri-state DQ drive is done in the top of the block with a single `dq_oe` register.

## Test plan
- Single write: port 0 writes addr 0x00010, data 0xA5A5. Expect gnt0 in N, `WE_N`=0 in N+1 only, DQ=0xA5A5 in N+1 and N+2, `o_busy` high for N+1 and N+2.
- Read-back: port 1 reads 0x00010 with the SRAM model holding 0xA5A5. Expect `o_rvalid[1]` in N+2 with `o_rdata`=0xA5A5, and `o_rvalid[0]` stays 0.
- Contention: both ports request continuously for 8 grants.
  - RR_EN: alternating 0, 1, 0, 1…
  - Without RR_EN: all grants to port 0, port 1 never granted.
- Back-to-back reads on port 1, 4 addresses: grants every 2 cycles, `o_rvalid` coincides with the next `o_gnt`, data in address order.
- Reset asserted in the ACCESS cycle of a read: no `o_rvalid`. The next cycle shows `WE_N`/`OE_N`/`CE_N`=1, DQ hi-Z, `o_busy`=0.
- Idle bus: no requests for 20 cycles. DQ stays hi-Z, no `o_gnt`, `OE_N`=`WE_N`=1.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_PORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RECOVER
  } state_t;

  typedef logic [0:0] port_id_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection. SRAM_ARB_RR_EN selects round-robin,
// otherwise port 0 has fixed priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] i_req,
`ifdef SRAM_ARB_RR_EN
  input  port_id_t           i_ptr,
`endif
  output logic               o_any_c,
  output port_id_t           o_winner_c
);

  always_comb begin
    o_any_c    = |i_req;
`ifdef SRAM_ARB_RR_EN
    // Favoured port wins when requesting, otherwise the other one.
    if (i_req[i_ptr]) o_winner_c = i_ptr;
    else              o_winner_c = ~i_ptr;
`else
    if (i_req[0]) o_winner_c = port_id_t'(0);
    else          o_winner_c = port_id_t'(1);
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared 16-bit async SRAM (recorder writes, DSP reads).
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = sram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = sram_arb_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic [1:0]        o_gnt,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rvalid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_gnt;
  port_id_t            r_lat_port;
  logic                r_lat_we;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic [DATA_W-1:0]   r_lat_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rvalid;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we_n;
  logic                r_oe_n;
  logic                r_ce_n;
  logic                r_dq_oe;
  logic [DATA_W-1:0]   r_dq_out;

  logic                w_any;
  port_id_t            w_winner;
  logic                w_grant;
  logic                w_acc_nxt;
  logic                w_rd_done;

`ifdef SRAM_ARB_RR_EN
  port_id_t            r_ptr;

  sram_arb_pick u_pick (
    .i_req      (i_req),
    .i_ptr      (r_ptr),
    .o_any_c    (w_any),
    .o_winner_c (w_winner)
  );
`else
  sram_arb_pick u_pick (
    .i_req      (i_req),
    .o_any_c    (w_any),
    .o_winner_c (w_winner)
  );
`endif

  // Next state and next registered strobe values.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|r_gnt) w_state_nxt = ST_ACCESS;
      ST_ACCESS:  w_state_nxt = r_lat_we ? ST_RECOVER : ST_IDLE;
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    // A grant is issued into any IDLE cycle that is not already a grant cycle.
    w_grant   = (w_state_nxt == ST_IDLE) && w_any;
    w_acc_nxt = (w_state_nxt == ST_ACCESS);
    w_rd_done = (r_state == ST_ACCESS) && !r_lat_we;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant, request latch and read return.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt       <= '0;
      r_lat_port  <= port_id_t'(0);
      r_lat_we    <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_grant) begin
        r_gnt[w_winner] <= 1'b1;
        r_lat_port      <= w_winner;
        r_lat_we        <= i_we[w_winner];
        r_lat_addr      <= (w_winner == port_id_t'(1)) ? i_addr1 : i_addr0;
        r_lat_wdata     <= (w_winner == port_id_t'(1)) ? i_wdata1 : i_wdata0;
      end
      if (w_rd_done) begin
        r_rvalid[r_lat_port] <= 1'b1;
        r_rdata              <= io_SRAM_DQ;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_ptr <= port_id_t'(0);
    else if (w_grant) r_ptr <= ~w_winner;
  end
`endif

  // SRAM pin registers; DQ stays driven through RECOVER to hold data past WE_N rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ce_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= '0;
    end else begin
      r_ce_n  <= 1'b0;
      r_we_n  <= !(w_acc_nxt && r_lat_we);
      r_oe_n  <= !(w_acc_nxt && !r_lat_we);
      r_dq_oe <= (w_acc_nxt && r_lat_we) || (w_state_nxt == ST_RECOVER);
      if (w_acc_nxt) begin
        r_addr   <= r_lat_addr;
        r_dq_out <= r_lat_wdata;
      end
    end
  end

  assign io_SRAM_DQ  = r_dq_oe ? r_dq_out : 'z;
  assign o_gnt       = r_gnt;
  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_busy      = r_busy;
  assign o_SRAM_ADDR = r_addr;
  assign o_SRAM_WE_N = r_we_n;
  assign o_SRAM_OE_N = r_oe_n;
  assign o_SRAM_CE_N = r_ce_n;
  assign o_SRAM_LB_N = r_ce_n;
  assign o_SRAM_UB_N = r_ce_n;

endmodule
